// File: rtl/mmio_pkg.sv
// Shared MMIO constants for the UART receive/transmit buffers.
//   UART_WIDTH    : data bits per UART character
//   FIFO_DEPTH    : default RX/TX queue depth
//   DROP_CNT_W    : width of the dropped-byte counter
//   STAT_*        : bit positions in the MMIO status word
//   sat_inc()     : saturating increment for the drop counter
package mmio_pkg;

  localparam int unsigned UART_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned DROP_CNT_W = 16;

  localparam int unsigned STAT_TX_READY = 0;
  localparam int unsigned STAT_RX_VALID = 1;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (v == '1) ? v : v + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ring_ptr.sv
// Circular pointer: increments modulo 2^W when inc is high.
//   clk : clock
//   rst : asynchronous active-low reset (ptr -> 0)
//   inc : advance pointer this cycle
//   ptr : current pointer value
module ring_ptr #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte queue between the UART receiver and the MMIO data path.
//   clk            : clock
//   rst            : asynchronous active-low reset
//   rx_data_in     : byte from receiver
//   rx_valid       : single-cycle strobe for rx_data_in
//   rx_ready       : queue not full (informational; receiver never stalls)
//   data_out       : head byte, 0 when empty
//   data_out_valid : queue non-empty (MMIO status rx-valid bit)
//   data_out_ready : pop request from MMIO data-register read
//   count          : occupancy 0..DEPTH
//   overflow       : sticky, set when a byte is dropped
//   clr_overflow   : clears overflow and drop_count
//   drop_count     : dropped bytes, saturating
module uart_rx_fifo
  import mmio_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned WIDTH = UART_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           rx_data_in,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic [WIDTH-1:0]           data_out,
  output logic                       data_out_valid,
  input  logic                       data_out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       clr_overflow,
  output logic [DROP_CNT_W-1:0]      drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop;

  always_comb begin
    full = (count == FULL_CNT);
    pop  = data_out_ready && data_out_valid;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    push = rx_valid && (!full || pop);
    drop = rx_valid && full && !pop;
  end

  ring_ptr #(.W(AW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  ring_ptr #(.W(AW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop coinciding with clr_overflow wins: the counter restarts at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= clr_overflow ? DROP_CNT_W'(1) : sat_inc(drop_count);
    end else if (clr_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  always_comb begin
    data_out_valid = (count != '0);
    rx_ready       = !full;
    data_out       = data_out_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data_in = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        data_out_ready = 1'b0;
  logic [3:0]  count;
  logic        overflow;
  logic        clr_overflow = 1'b0;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  // Scoreboard state
  logic [7:0]  mq[$];
  logic        movf = 1'b0;
  logic [15:0] mdrop = '0;
  logic [7:0]  last_pop = '0;
  int          max_cnt = 0;

  uart_rx_fifo #(.DEPTH(8), .WIDTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_data_in     (rx_data_in),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .count          (count),
    .overflow       (overflow),
    .clr_overflow   (clr_overflow),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the head is checked before the edge, state after.
  task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
    logic [7:0] exp_head;
    logic full_m, pop_m, push_m, drop_m;
    @(negedge clk);
    rx_valid = v; rx_data_in = d; data_out_ready = r; clr_overflow = c;
    #1;
    exp_head = (mq.size() != 0) ? mq[0] : 8'h00;
    checks++;
    if (data_out !== exp_head || data_out_valid !== (mq.size() != 0)) begin
      errors++;
      $display("FAIL head got %02h/%b exp %02h/%b", data_out, data_out_valid, exp_head, mq.size() != 0);
    end
    full_m = (mq.size() == 8);
    pop_m  = r && (mq.size() != 0);
    push_m = v && (!full_m || pop_m);
    drop_m = v && full_m && !pop_m;
    if (pop_m) last_pop = mq.pop_front();
    if (push_m) mq.push_back(d);
    if (drop_m) begin
      movf  = 1'b1;
      mdrop = c ? 16'd1 : ((mdrop == 16'hFFFF) ? mdrop : mdrop + 16'd1);
    end else if (c) begin
      movf  = 1'b0;
      mdrop = '0;
    end
    if (mq.size() > max_cnt) max_cnt = mq.size();
    @(posedge clk);
    #1;
    rx_valid = 1'b0; data_out_ready = 1'b0; clr_overflow = 1'b0;
    checks++;
    if (count !== 4'(mq.size()) || rx_ready !== (mq.size() != 8)) begin
      errors++;
      $display("FAIL count got %0d/%b exp %0d/%b", count, rx_ready, mq.size(), mq.size() != 8);
    end
    checks++;
    if (overflow !== movf || drop_count !== mdrop) begin
      errors++;
      $display("FAIL ovf got %b/%0d exp %b/%0d", overflow, drop_count, movf, mdrop);
    end
  endtask

  task automatic test_reset();
    #12 rst = 1'b1;
    checks++;
    if ({data_out_valid, data_out, rx_ready, count, overflow, drop_count} !== {1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL reset got v%b d%02h r%b c%0d o%b dc%0d exp v0 d00 r1 c0 o0 dc0",
               data_out_valid, data_out, rx_ready, count, overflow, drop_count);
    end
  endtask

  task automatic test_basic();
    logic [7:0] bytes [3] = '{8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 3; i++) step(1'b1, bytes[i], 1'b0, 1'b0);
    checks++;
    if (count !== 4'd3) begin errors++; $display("FAIL basic_cnt got %0d exp 3", count); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (last_pop !== bytes[i]) begin
        errors++; $display("FAIL basic_order got %02h exp %02h", last_pop, bytes[i]);
      end
    end
    checks++;
    if (data_out_valid !== 1'b0 || count !== 4'd0) begin
      errors++; $display("FAIL basic_empty got v%b c%0d exp v0 c0", data_out_valid, count);
    end
    // Pop while empty must be ignored
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    checks++;
    if (count !== 4'd8 || rx_ready !== 1'b0 || overflow !== 1'b1 || drop_count !== 16'd2) begin
      errors++;
      $display("FAIL ovf_fill got c%0d r%b o%b dc%0d exp c8 r0 o1 dc2", count, rx_ready, overflow, drop_count);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (last_pop !== 8'(i)) begin
        errors++; $display("FAIL ovf_order got %02h exp %02h", last_pop, 8'(i));
      end
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    checks++;
    if (count !== 4'd8 || drop_count !== 16'd2 || last_pop !== 8'h30) begin
      errors++;
      $display("FAIL full_pp got c%0d dc%0d p%02h exp c8 dc2 p30", count, drop_count, last_pop);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++;
    if (last_pop !== 8'hAA) begin
      errors++; $display("FAIL full_pp_last got %02h exp aa", last_pop);
    end
  endtask

  task automatic test_wrap_and_clr();
    max_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (last_pop !== 8'h10 + 8'(i)) begin
        errors++; $display("FAIL wrap_order got %02h exp %02h", last_pop, 8'h10 + 8'(i));
      end
    end
    checks++;
    if (max_cnt > 1) begin errors++; $display("FAIL wrap_max got %0d exp 1", max_cnt); end
    for (int i = 0; i < 8; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b1 || drop_count !== 16'd1) begin
      errors++; $display("FAIL clr_drop got o%b dc%0d exp o1 dc1", overflow, drop_count);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0 || drop_count !== 16'd0) begin
      errors++; $display("FAIL clr got o%b dc%0d exp o0 dc0", overflow, drop_count);
    end
  endtask

  task automatic test_async_reset();
    while (mq.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h07, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
    checks++;
    if (count !== 4'd5) begin errors++; $display("FAIL rst_pre got %0d exp 5", count); end
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({data_out_valid, data_out, rx_ready, count, overflow, drop_count} !== {1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL async_rst got v%b d%02h r%b c%0d o%b dc%0d exp v0 d00 r1 c0 o0 dc0",
               data_out_valid, data_out, rx_ready, count, overflow, drop_count);
    end
    mq.delete(); movf = 1'b0; mdrop = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    step(1'b1, 8'h55, 1'b0, 1'b0);
    checks++;
    if (data_out !== 8'h55 || count !== 4'd1) begin
      errors++; $display("FAIL post_rst got %02h c%0d exp 55 c1", data_out, count);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_wrap_and_clr();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
